// File: rtl/clb_cfg_if.sv
// Bit-serial configuration stream handshake between a stream source and the CLB loader.
interface clb_cfg_if;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (output cfg_valid, output cfg_bit, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_bit, output cfg_ready);
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: assembles CFG_W-bit words MSB-first and writes them to CLBs 0..N_CLB-1.
// Optional per-word even parity check is enabled by defining CLB_CFG_PARITY_EN.
module clb_cfg_loader #(
  parameter int N_CLB = 16,
  parameter int CFG_W = 23,
  parameter int IDX_W = $clog2(N_CLB)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  clb_cfg_if.slave         cfg,
  output logic [CFG_W-1:0] clb_bits,
  output logic [N_CLB-1:0] clb_wr_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(CFG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLB - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CFG_W-1:0]   shreg_r;
  logic [N_CLB-1:0]   wr_en_r;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;

`ifdef CLB_CFG_PARITY_EN
  // Nonzero when word plus parity bit does not have even parity.
  function automatic logic parity_bad(input logic [CFG_W-1:0] word, input logic par);
    return ^{word, par};
  endfunction
`endif

  // Load sequencer; every output is registered and updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      shreg_r   <= {CFG_W{1'b0}};
      wr_en_r   <= {N_CLB{1'b0}};
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_r   <= SHIFT;
            idx_r     <= {IDX_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b1;
            ready_r   <= 1'b1;
          end
        end
        SHIFT: begin
          if (cfg.cfg_valid && ready_r) begin
            shreg_r <= {shreg_r[CFG_W-2:0], cfg.cfg_bit};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= {CNT_W{1'b0}};
`ifdef CLB_CFG_PARITY_EN
              state_r   <= CHECK;
`else
              state_r   <= WRITE;
              ready_r   <= 1'b0;
              wr_en_r   <= N_CLB'(1) << idx_r;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
`ifdef CLB_CFG_PARITY_EN
        CHECK: begin
          if (cfg.cfg_valid && ready_r) begin
            ready_r <= 1'b0;
            if (!parity_bad(shreg_r, cfg.cfg_bit)) begin
              state_r <= WRITE;
              wr_en_r <= N_CLB'(1) << idx_r;
            end else begin
              // Failed word is dropped; earlier CLBs keep what they were given.
              state_r <= ERROR;
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
            end
          end
        end
`endif
        WRITE: begin
          wr_en_r <= {N_CLB{1'b0}};
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            state_r <= SHIFT;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= {N_CLB{1'b0}};
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_r;
  assign clb_bits      = shreg_r;
  assign clb_wr_en     = wr_en_r;
  assign busy          = busy_r;
  assign done          = done_r;
`ifdef CLB_CFG_PARITY_EN
  assign err           = err_r;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader with N_CLB=4: clean, stalled, ignored-start, reset and parity scenarios.
module tb_clb_cfg_loader;
  localparam int N = 4;
  localparam int W = 23;
`ifdef CLB_CFG_PARITY_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] clb_bits;
  logic [N-1:0] clb_wr_en;
  logic         busy, done, err;

  clb_cfg_if cfg_bus();

  clb_cfg_loader #(.N_CLB(N), .CFG_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg_bus),
    .clb_bits(clb_bits), .clb_wr_en(clb_wr_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [N-1:0] ev_wr[$];
  logic [W-1:0] ev_bits[$];
  int           ev_cyc[$];
  logic         ev_rdy[$];
  logic [W-1:0] clb_mem [N];

  logic [W-1:0] wa [4] = '{23'h7FFFFF, 23'h400001, 23'h2AAAAA, 23'h000000};
  logic [W-1:0] wb [4] = '{23'h123456, 23'h654321, 23'h0F0F0F, 23'h7C3E1F};

  always @(posedge clk) cyc <= cyc + 1;

  // Records every write strobe seen in a cycle, plus the word and ready state alongside it.
  always @(negedge clk) begin
    if (clb_wr_en !== {N{1'b0}}) begin
      ev_wr.push_back(clb_wr_en);
      ev_bits.push_back(clb_bits);
      ev_cyc.push_back(cyc - start_cyc + 1);
      ev_rdy.push_back(cfg_bus.cfg_ready);
    end
  end

  // CLB array model: captures on the edge that ends the write cycle.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (clb_wr_en[i]) clb_mem[i] <= clb_bits;
  end

  task automatic do_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    ev_wr.delete(); ev_bits.delete(); ev_cyc.delete(); ev_rdy.delete();
    vectors += 3;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s start_busy got=%b want=1", name, busy); end
    if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL %s start_ready got=%b want=1", name, cfg_bus.cfg_ready); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL %s start_done got=%b want=0", name, done); end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    bit ok;
    ok = 1'b0;
    if (stall) begin
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
    end
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_bit   = b;
      ok = cfg_bus.cfg_ready;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_bit_timeout got=ready0 want=ready1 within 64 cycles");
    end
  endtask

  // Sends bits hi..lo of a word; the even-parity bit follows when the word is completed.
  task automatic send_word(input logic [W-1:0] w, input bit stall, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i], stall);
`ifdef CLB_CFG_PARITY_EN
    if (lo == 0) send_bit(^w, stall);
`endif
  endtask

  task automatic check_load(input logic [W-1:0] words [4], input bit timed, input string name);
    int rel;
    int prev;
    logic [N-1:0] exp_wr;
    rel = -1;
    for (int n = 0; n < 300 && rel < 0; n++) begin
      @(negedge clk);
      if (done === 1'b1) rel = cyc - start_cyc + 1;
    end
    vectors += 3;
    if (rel < 0) begin miscompares++; $display("FAIL %s done_timeout got=0 want=1", name); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s done_busy got=%b want=0", name, busy); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL %s done_err got=%b want=0", name, err); end
    if (timed) begin
      vectors++;
      if (rel != N * LAT + 1) begin miscompares++; $display("FAIL %s done_cycle got=%0d want=%0d", name, rel, N * LAT + 1); end
    end
    vectors++;
    if (ev_wr.size() != N) begin miscompares++; $display("FAIL %s write_count got=%0d want=%0d", name, ev_wr.size(), N); end
    prev = 0;
    for (int i = 0; i < N && i < ev_wr.size(); i++) begin
      exp_wr = 4'b0001 << i;
      vectors += 5;
      if (ev_wr[i] !== exp_wr) begin miscompares++; $display("FAIL %s wr_en[%0d] got=%b want=%b", name, i, ev_wr[i], exp_wr); end
      if (ev_bits[i] !== words[i]) begin miscompares++; $display("FAIL %s clb_bits[%0d] got=%h want=%h", name, i, ev_bits[i], words[i]); end
      if (ev_rdy[i] !== 1'b0) begin miscompares++; $display("FAIL %s ready_in_write[%0d] got=%b want=0", name, i, ev_rdy[i]); end
      if (clb_mem[i] !== words[i]) begin miscompares++; $display("FAIL %s clb_mem[%0d] got=%h want=%h", name, i, clb_mem[i], words[i]); end
      if (timed ? (ev_cyc[i] != LAT * (i + 1)) : (ev_cyc[i] <= prev + LAT)) begin
        miscompares++; $display("FAIL %s write_cycle[%0d] got=%0d want=%0d", name, i, ev_cyc[i], LAT * (i + 1));
      end
      prev = ev_cyc[i];
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors += 6;
    if (cfg_bus.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL %s cfg_ready got=%b want=0", name, cfg_bus.cfg_ready); end
    if (clb_bits !== {W{1'b0}}) begin miscompares++; $display("FAIL %s clb_bits got=%h want=0", name, clb_bits); end
    if (clb_wr_en !== {N{1'b0}}) begin miscompares++; $display("FAIL %s clb_wr_en got=%b want=0", name, clb_wr_en); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy got=%b want=0", name, busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL %s done got=%b want=0", name, done); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL %s err got=%b want=0", name, err); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (cfg_bus.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got=%b want=0", cfg_bus.cfg_ready); end
  endtask

  task automatic test_clean_load();
    do_start("clean");
    for (int i = 0; i < N; i++) send_word(wa[i], 1'b0, W - 1, 0);
    check_load(wa, 1'b1, "clean");
  endtask

  task automatic test_stalled();
    do_start("stalled");
    for (int i = 0; i < N; i++) send_word(wa[i], 1'b1, W - 1, 0);
    check_load(wa, 1'b0, "stalled");
  endtask

  task automatic test_ignored_start();
    do_start("restart");
    send_word(wb[0], 1'b0, W - 1, 0);
    send_word(wb[1], 1'b0, W - 1, 0);
    send_word(wb[2], 1'b0, W - 1, 13);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL ignored_start busy got=%b want=1", busy); end
    send_word(wb[2], 1'b0, 12, 0);
    send_word(wb[3], 1'b0, W - 1, 0);
    check_load(wb, 1'b1, "ignored_start");
  endtask

  task automatic test_reset_mid_load();
    do_start("midreset");
    send_word(wa[0], 1'b0, W - 1, 0);
    send_word(wa[1], 1'b0, W - 1, 18);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    do_start("after_reset");
    for (int i = 0; i < N; i++) send_word(wb[i], 1'b0, W - 1, 0);
    check_load(wb, 1'b1, "after_reset");
  endtask

`ifdef CLB_CFG_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] bad;
    bit seen;
    bad = 23'h000003;
    do_start("parity");
    send_word(23'h000001, 1'b0, W - 1, 0);
    send_word(bad, 1'b0, W - 1, 1);
    send_bit(bad[0], 1'b0);
    send_bit(1'b1, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = (err === 1'b1);
    end
    vectors += 5;
    if (!seen) begin miscompares++; $display("FAIL parity err got=0 want=1"); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL parity busy got=%b want=0", busy); end
    if (cfg_bus.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL parity ready got=%b want=0", cfg_bus.cfg_ready); end
    if (ev_wr.size() != 1) begin miscompares++; $display("FAIL parity write_count got=%0d want=1", ev_wr.size()); end
    if (ev_wr.size() > 0 && ev_wr[0] !== 4'b0001) begin miscompares++; $display("FAIL parity wr_en0 got=%b want=0001", ev_wr[0]); end
  endtask
`endif

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_bit   = 1'b0;
    test_reset();
    test_clean_load();
    test_stalled();
    test_ignored_start();
    test_reset_mid_load();
`ifdef CLB_CFG_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
